and_result_uart_tx: RTL and testbench
=====================================

// Module: and_result_uart_tx
// PURPOSE
//  Serial transmitter for the 8-bit AND-unit result.
//  - Accepts one byte per valid/ready handshake from the parallel result path.
//  - Sends it as an 8N1 UART frame on a single output pin (optional even parity), LSB first.
//  - Sits between the AND/adder core output and a dedicated uo_out pin.
//  - Lets a host read results serially instead of occupying all 8 output pins.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per UART bit; legal range 2..65535
//  PARITY_EN     0   1 = insert even-parity bit between data and stop; 0 = no parity bit
// PORTS
//  clk       in   1  system clock; all logic on rising edge
//  rst_n     in   1  reset, asynchronous assert, active-low
//  ena       in   1  design enable; 0 freezes all state (counters, FSM, tx level held)
//  in_data   in   8  result byte to send; sampled only on accept
//  in_valid  in   1  in_data valid
//  in_ready  out  1  transmitter can accept a byte
//  tx        out  1  serial line; idle high
//  busy      out  1  frame in progress (any state except IDLE)
// BEHAVIOUR
//  Reset values (asynchronous, while rst_n=0)
//   - tx=1, in_ready=0, busy=0, state=IDLE, counters=0, shift register=0.
//   - in_ready rises on the first clk edge after rst_n deasserts.
//  Handshake
//   - Accept when in_valid & in_ready at a rising edge with ena=1.
//   - in_ready=1 only in IDLE. It is registered and drops the cycle after accept.
//   - in_valid without in_ready is ignored; nothing is queued.
//   - Upstream may change in_data freely after accept; data is latched on accept.
//  FSM states: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE
//   - IDLE: tx=1. On accept, latch in_data and parity (^in_data) and go to START.
//   - START: tx=0 for CLKS_PER_BIT cycles.
//   - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit.
//     Bit index 0..7; leave DATA after bit 7.
//   - PARITY: tx=even parity for CLKS_PER_BIT cycles.
//   - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE and raise in_ready.
//  Timing
//   - tx falls on the first edge after the accept edge (latency 1 cycle).
//   - Frame length is (10 + PARITY_EN)*CLKS_PER_BIT cycles.
//   - Next accept is possible one cycle after the STOP bit ends (1-cycle idle gap min).
//  Arithmetic and widths
//   - Baud counter is $clog2(CLKS_PER_BIT) bits wide.
//   - It counts 0..CLKS_PER_BIT-1 and wraps to 0 on the bit tick; no off-by-one.
//   - Bit index is 3 bits; wrap from 7 is never used (the FSM exits first).
//   - tx is registered; no glitches.
//  Boundary conditions
//   - in_valid held high continuously: back-to-back frames separated by exactly one IDLE cycle.
//   - ena=0 mid-bit: that bit is extended by the paused cycles; no bit is lost.
//   - rst_n low mid-frame: tx goes to 1 immediately; the partial frame is abandoned.
//   - CLKS_PER_BIT=2: must still meet exact timing; the counter width is at least 1.
// STRUCTURE
//  - Package and_uart_pkg:
//    - state enum {IDLE, START, DATA, PARITY, STOP}
//    - DATA_BITS=8
//    - function cnt_w(CLKS_PER_BIT) returning the counter width
//  - Sub-module and_uart_baud_gen:
//    - Free counter with a restart input; asserts bit_tick on the last cycle of each bit.
//    - Restarts on accept so the start bit is exactly CLKS_PER_BIT cycles long.
//  - Top-level wiring:
//    - tx drives uo_out[0], busy drives uo_out[1].
//    - in_data comes from the AND result; in_valid comes from uio_in[0].
// TESTING
//  1. Reset, then send 0xA5 (CLKS_PER_BIT=16, PARITY_EN=0) -> tx reads 0,1,0,1,0,0,1,0,1,1
//     (start, LSB-first data, stop), each bit 16 cycles; in_ready high again at cycle 161.
//  2. PARITY_EN=1, send 0x07 -> parity bit 1, frame 176 cycles.
//     PARITY_EN=1, send 0x03 -> parity bit 0.
//  3. in_valid held high with 0x00 then 0xFF -> two frames, exactly one idle-high cycle between
//     them; 0xFF frame data bits all 1.
//  4. rst_n pulsed low during data bit 3 of 0x55 -> tx=1 that same cycle, busy=0.
//     After release the next accept sends a full clean frame.
//  5. ena=0 for 5 cycles inside the start bit of 0x81 -> start bit measures 21 cycles;
//     remaining bits 16 each.
//  6. CLKS_PER_BIT=2, send 0x3C -> 20-cycle frame, correct bit pattern, no counter overflow.

Source files
------------

// File: rtl/and_uart_pkg.sv
// Shared types and constants for the AND-result UART transmitter.
package and_uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   // Baud counter width; never below 1 bit so CLKS_PER_BIT=2 still has a counter.
   function automatic int cnt_w(input int clks_per_bit);
      int w;
      w = $clog2(clks_per_bit);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/and_result_uart_tx_if.sv
// Parallel result handshake feeding the UART transmitter.
interface and_result_uart_tx_if;
   import and_uart_pkg::*;

   logic [DATA_BITS-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/and_uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit. Restart realigns the count to the accepted byte so the start bit
// is exactly one bit period long.
module and_uart_baud_gen
   import and_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic restart,
   output logic bit_tick
);

   localparam int            CW   = cnt_w(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   assign bit_tick = ena && (cnt == LAST);

   // Free-running bit counter, frozen while ena is low.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values and simulation matches the synthesized registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (ena) begin
         if (restart || (cnt == LAST)) cnt <= '0;
         else                          cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/and_result_uart_tx.sv
// Serial transmitter for the 8-bit AND-unit result: one byte per valid/ready
// handshake, sent as an 8N1 frame (optional even parity), LSB first.
// At chip level tx feeds uo_out[0] and busy feeds uo_out[1].
module and_result_uart_tx
   import and_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter bit PARITY_EN    = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ena,
   and_result_uart_tx_if.slave        result,
   output logic                       tx,
   output logic                       busy
);

   state_t               state;
   logic [DATA_BITS-1:0] shift;
   logic                 parity;
   logic [2:0]           bit_idx;
   logic                 ready;
   logic                 bit_tick;
   logic                 accept;

   assign accept          = ena && ready && result.in_valid;
   assign result.in_ready = ready;
   assign busy            = (state != IDLE);

   and_uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .restart (accept),
      .bit_tick(bit_tick)
   );

   // Frame sequencer; tx and in_ready are registered alongside the state.
   // NOTE: every branch that does not assign a signal simply holds the flop;
   // inside always_ff that is a register, never a latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tx      <= 1'b1;
         ready   <= 1'b0;
         shift   <= '0;
         parity  <= 1'b0;
         bit_idx <= '0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state  <= START;
                  tx     <= 1'b0;
                  ready  <= 1'b0;
                  shift  <= result.in_data;
                  parity <= ^result.in_data;
               end else begin
                  ready <= 1'b1;
               end
            end
            START: begin
               if (bit_tick) begin
                  state   <= DATA;
                  tx      <= shift[0];
                  bit_idx <= '0;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  if (bit_idx == 3'(DATA_BITS - 1)) begin
                     if (PARITY_EN) begin
                        state <= PARITY;
                        tx    <= parity;
                     end else begin
                        state <= STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (bit_tick) begin
                  state <= STOP;
                  tx    <= 1'b1;
               end
            end
            STOP: begin
               if (bit_tick) begin
                  state <= IDLE;
                  ready <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_and_result_uart_tx.sv
// Scoreboard bench for and_result_uart_tx: three instances (16 clk/bit,
// 16 clk/bit with parity, 2 clk/bit). Stimulus pushes expected frames;
// per-instance monitors decode tx cycle by cycle and compare.
module tb_and_result_uart_tx;
   import and_uart_pkg::*;

   typedef struct packed {
      logic [10:0]       bits;   // bits[i] = i-th transmitted bit
      logic [3:0]        nbits;
      logic [10:0][15:0] lens;   // cycles per bit
      logic              b2b;    // next frame must follow after one idle cycle
   } frame_t;

   logic clk = 1'b0;
   logic rst_n, rst_n_a, ena_a, ena_on;
   logic tx_a, tx_b, tx_c, busy_a, busy_b, busy_c;

   and_result_uart_tx_if if_a ();
   and_result_uart_tx_if if_b ();
   and_result_uart_tx_if if_c ();

   and_result_uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1'b0)) u_dut_a (
      .clk(clk), .rst_n(rst_n_a), .ena(ena_a), .result(if_a), .tx(tx_a), .busy(busy_a));
   and_result_uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1'b1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .ena(ena_on), .result(if_b), .tx(tx_b), .busy(busy_b));
   and_result_uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1'b0)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .ena(ena_on), .result(if_c), .tx(tx_c), .busy(busy_c));

   initial forever #5 clk = ~clk;

   int     n_tests = 0;
   int     n_fail  = 0;
   frame_t q_a[$], q_b[$], q_c[$];
   int     pushed[3];
   int     done[3];
   bit     hold_a;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic get_tx(input int w);
      case (w)
         0:       return tx_a;
         1:       return tx_b;
         default: return tx_c;
      endcase
   endfunction

   function automatic logic get_ready(input int w);
      case (w)
         0:       return if_a.in_ready;
         1:       return if_b.in_ready;
         default: return if_c.in_ready;
      endcase
   endfunction

   function automatic logic get_busy(input int w);
      case (w)
         0:       return busy_a;
         1:       return busy_b;
         default: return busy_c;
      endcase
   endfunction

   task automatic drive(input int w, input logic v, input logic [7:0] d);
      case (w)
         0:       begin if_a.in_valid = v; if_a.in_data = d; end
         1:       begin if_b.in_valid = v; if_b.in_data = d; end
         default: begin if_c.in_valid = v; if_c.in_data = d; end
      endcase
   endtask

   function automatic frame_t mk(input logic [10:0] bits, input int nbits, input int clks,
                                 input bit b2b);
      frame_t f;
      f.bits  = bits;
      f.nbits = 4'(nbits);
      f.b2b   = b2b;
      for (int i = 0; i < 11; i++) f.lens[i] = 16'(clks);
      return f;
   endfunction

   task automatic push(input int w, input frame_t f);
      case (w)
         0:       q_a.push_back(f);
         1:       q_b.push_back(f);
         default: q_c.push_back(f);
      endcase
      pushed[w]++;
   endtask

   function automatic int q_size(input int w);
      case (w)
         0:       return q_a.size();
         1:       return q_b.size();
         default: return q_c.size();
      endcase
   endfunction

   function automatic frame_t pop(input int w);
      case (w)
         0:       return q_a.pop_front();
         1:       return q_b.pop_front();
         default: return q_c.pop_front();
      endcase
   endfunction

   // Decodes one instance's tx line and compares against the queued frames.
   task automatic monitor(input int w);
      frame_t f;
      int     bad;
      bit     pending;
      pending = 1'b0;
      forever begin
         if (!pending) @(negedge clk);
         pending = 1'b0;
         if (get_tx(w) === 1'b0 && !(w == 0 && hold_a)) begin
            check($sformatf("dut%0d_start_expected", w), q_size(w) > 0, 1);
            if (q_size(w) == 0) begin
               for (int i = 0; i < 2000 && get_tx(w) === 1'b0; i++) @(negedge clk);
            end else begin
               f = pop(w);
               for (int b = 0; b < int'(f.nbits); b++) begin
                  bad = 0;
                  for (int c = 0; c < int'(f.lens[b]); c++) begin
                     if (!(b == 0 && c == 0)) @(negedge clk);
                     if (get_tx(w) !== f.bits[b]) bad++;
                  end
                  check($sformatf("dut%0d_bit%0d_bad_cycles", w, b), bad, 0);
               end
               @(negedge clk);
               check($sformatf("dut%0d_idle_tx", w), get_tx(w), 1);
               check($sformatf("dut%0d_ready_after_stop", w), get_ready(w), 1);
               check($sformatf("dut%0d_busy_after_stop", w), get_busy(w), 0);
               if (f.b2b) begin
                  @(negedge clk);
                  check($sformatf("dut%0d_b2b_start", w), get_tx(w), 0);
                  pending = 1'b1;
               end
               done[w]++;
            end
         end
      end
   endtask

   // Offers a byte, waits (bounded) for the accept edge, returns in the
   // cycle right after accept with in_data scrambled.
   task automatic send(input int w, input logic [7:0] d, input bit keep);
      int guard;
      @(negedge clk);
      drive(w, 1'b1, d);
      guard = 0;
      while (get_ready(w) !== 1'b1 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check($sformatf("dut%0d_ready_seen", w), guard < 2000, 1);
      @(posedge clk);
      @(negedge clk);
      drive(w, keep, ~d);
      check($sformatf("dut%0d_ready_drop", w), get_ready(w), 0);
      check($sformatf("dut%0d_tx_latency", w), get_tx(w), 0);
   endtask

   task automatic wait_done(input int w);
      int guard;
      guard = 0;
      while (done[w] != pushed[w] && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      check($sformatf("dut%0d_frames_done", w), done[w], pushed[w]);
   endtask

   initial begin
      frame_t f;
      rst_n   = 1'b0;
      rst_n_a = 1'b0;
      ena_a   = 1'b1;
      ena_on  = 1'b1;
      hold_a  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(i, 1'b0, 8'h00);
         pushed[i] = 0;
         done[i]   = 0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("dut%0d_rst_tx", i), get_tx(i), 1);
         check($sformatf("dut%0d_rst_ready", i), get_ready(i), 0);
         check($sformatf("dut%0d_rst_busy", i), get_busy(i), 0);
      end
      rst_n   = 1'b1;
      rst_n_a = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) check($sformatf("dut%0d_ready_after_rst", i), get_ready(i), 1);

      fork
         monitor(0);
         monitor(1);
         monitor(2);
      join_none

      // 0xA5, no parity: 0,1,0,1,0,0,1,0,1,1
      push(0, mk(11'b0_1101001010, 10, 16, 1'b0));
      send(0, 8'hA5, 1'b0);
      check("dut0_busy_in_frame", get_busy(0), 1);
      wait_done(0);

      // Even parity: 0x07 -> parity 1, 0x03 -> parity 0
      push(1, mk(11'b11_00000111_0, 11, 16, 1'b0));
      send(1, 8'h07, 1'b0);
      wait_done(1);
      push(1, mk(11'b10_00000011_0, 11, 16, 1'b0));
      send(1, 8'h03, 1'b0);
      wait_done(1);

      // Two clocks per bit: 0x3C
      push(2, mk(11'b0_1001111000, 10, 2, 1'b0));
      send(2, 8'h3C, 1'b0);
      wait_done(2);

      // in_valid held: 0x00 then 0xFF with a single idle cycle between
      push(0, mk(11'b0_1000000000, 10, 16, 1'b1));
      push(0, mk(11'b0_1111111110, 10, 16, 1'b0));
      send(0, 8'h00, 1'b1);
      send(0, 8'hFF, 1'b0);
      wait_done(0);

      // Reset during data bit 3 of 0x55 (bit value 0)
      hold_a = 1'b1;
      send(0, 8'h55, 1'b0);
      repeat (70) @(negedge clk);
      check("dut0_pre_rst_tx", get_tx(0), 0);
      #2 rst_n_a = 1'b0;
      #1;
      check("dut0_midframe_rst_tx", get_tx(0), 1);
      check("dut0_midframe_rst_busy", get_busy(0), 0);
      check("dut0_midframe_rst_ready", get_ready(0), 0);
      repeat (2) @(negedge clk);
      rst_n_a = 1'b1;
      hold_a  = 1'b0;
      @(negedge clk);
      check("dut0_ready_after_midrst", get_ready(0), 1);
      push(0, mk(11'b0_1010101010, 10, 16, 1'b0));
      send(0, 8'h55, 1'b0);
      wait_done(0);

      // ena low for 5 cycles inside the start bit of 0x81 -> start bit 21 cycles
      f = mk(11'b0_1100000010, 10, 16, 1'b0);
      f.lens[0] = 16'd21;
      push(0, f);
      send(0, 8'h81, 1'b0);
      repeat (3) @(negedge clk);
      ena_a = 1'b0;
      repeat (5) @(negedge clk);
      ena_a = 1'b1;
      wait_done(0);

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
